// File: rtl/tag_ctrl_2way.sv
`default_nettype none
// ============================================================================
// tag_ctrl_2way : lookup/fill/scrub sequencer for a 2-way x 32-set tag array
// Revision 1.0  : initial release
// ============================================================================
module tag_ctrl_2way #(
    parameter int ADDR_W = 32,
    parameter int OFF_W  = 4,
    parameter int IDX_W  = 5,
    parameter int TAG_W  = 23
) (
    input  logic              CK,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_way,
    input  logic              flush_req,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic              resp_way,
    output logic              resp_victim,
    output logic              busy,
    output logic              ta_cs,
    output logic              ta_oe,
    output logic [1:0]        ta_web,
    output logic [IDX_W-1:0]  ta_a,
    output logic [TAG_W-1:0]  ta_di,
    input  logic [TAG_W-1:0]  ta_do0,
    input  logic [TAG_W-1:0]  ta_do1
);

    localparam int SETS = 2 ** IDX_W;

    typedef enum logic [1:0] {
        ST_SWEEP = 2'd0,
        ST_IDLE  = 2'd1,
        ST_CMP   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   w_cnt_nxt;
    logic [SETS-1:0]    r_valid0;
    logic [SETS-1:0]    r_valid1;
    logic [SETS-1:0]    r_lru;
    logic [IDX_W-1:0]   r_idx;
    logic [TAG_W-1:0]   r_tag;

    logic               w_cap;
    logic               w_fill;
    logic               w_cmp;
    logic               w_clear;
    logic [IDX_W-1:0]   w_req_idx;
    logic [TAG_W-1:0]   w_req_tag;
    logic               w_accept;
    logic               w_hit0;
    logic               w_hit1;
    logic               w_hit;
    logic               w_hit_way;
    logic               w_cmp_victim;
    logic               w_fill_v0;
    logic               w_fill_v1;
    logic               w_fill_victim;
    logic               w_unused;

    assign w_req_idx = req_addr[OFF_W +: IDX_W];
    assign w_req_tag = req_addr[OFF_W + IDX_W +: TAG_W];
    assign w_unused  = ^req_addr[OFF_W-1:0];

    assign req_ready = (r_state == ST_IDLE) & ~flush_req;
    assign w_accept  = req_valid & req_ready;
    assign busy      = (r_state == ST_SWEEP);

    // Compare against the data returned for the address clocked in IDLE.
    assign w_hit0       = r_valid0[r_idx] & (ta_do0 == r_tag);
    assign w_hit1       = r_valid1[r_idx] & (ta_do1 == r_tag);
    assign w_hit        = w_hit0 | w_hit1;
    assign w_hit_way    = w_hit1 & ~w_hit0;
    assign w_cmp_victim = ~r_valid0[r_idx] ? 1'b0 :
                          ~r_valid1[r_idx] ? 1'b1 : r_lru[r_idx];

    // Victim reported for a fill reflects the set after the write lands.
    assign w_fill_v0     = r_valid0[w_req_idx] | ~req_way;
    assign w_fill_v1     = r_valid1[w_req_idx] |  req_way;
    assign w_fill_victim = ~w_fill_v0 ? 1'b0 :
                           ~w_fill_v1 ? 1'b1 : ~req_way;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cap       = 1'b0;
        w_fill      = 1'b0;
        w_cmp       = 1'b0;
        w_clear     = 1'b0;
        ta_cs       = 1'b0;
        ta_oe       = 1'b0;
        ta_web      = 2'b11;
        ta_a        = '0;
        ta_di       = '0;
        case (r_state)
            ST_SWEEP: begin
                ta_cs     = 1'b1;
                ta_web    = 2'b00;
                ta_a      = r_cnt;
                w_cnt_nxt = r_cnt + IDX_W'(1);
                if (r_cnt == IDX_W'(SETS - 1)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (flush_req) begin
                    w_state_nxt = ST_SWEEP;
                    w_cnt_nxt   = '0;
                    w_clear     = 1'b1;
                end else if (w_accept) begin
                    ta_cs = 1'b1;
                    ta_a  = w_req_idx;
                    if (!req_op) begin
                        ta_oe       = 1'b1;
                        w_cap       = 1'b1;
                        w_state_nxt = ST_CMP;
                    end else begin
                        ta_web = req_way ? 2'b01 : 2'b10;
                        ta_di  = w_req_tag;
                        w_fill = 1'b1;
                    end
                end
            end
            ST_CMP: begin
                w_cmp = 1'b1;
                if (flush_req) begin
                    w_state_nxt = ST_SWEEP;
                    w_cnt_nxt   = '0;
                    w_clear     = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_SWEEP;
                w_cnt_nxt   = '0;
                w_clear     = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CK) begin
        if (rst) begin
            r_state     <= ST_SWEEP;
            r_cnt       <= '0;
            r_valid0    <= '0;
            r_valid1    <= '0;
            r_lru       <= '0;
            r_idx       <= '0;
            r_tag       <= '0;
            resp_valid  <= 1'b0;
            resp_hit    <= 1'b0;
            resp_way    <= 1'b0;
            resp_victim <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            resp_valid <= 1'b0;
            if (w_cap) begin
                r_idx <= w_req_idx;
                r_tag <= w_req_tag;
            end
            if (w_fill) begin
                if (req_way) begin
                    r_valid1[w_req_idx] <= 1'b1;
                end else begin
                    r_valid0[w_req_idx] <= 1'b1;
                end
                r_lru[w_req_idx] <= ~req_way;
                resp_valid       <= 1'b1;
                resp_hit         <= 1'b0;
                resp_way         <= req_way;
                resp_victim      <= w_fill_victim;
            end
            if (w_cmp) begin
                resp_valid  <= 1'b1;
                resp_hit    <= w_hit;
                resp_way    <= w_hit_way;
                resp_victim <= w_cmp_victim;
                if (w_hit) begin
                    r_lru[r_idx] <= ~w_hit_way;
                end
            end
            // A flush overrides any LRU touch made on the same edge.
            if (w_clear) begin
                r_valid0 <= '0;
                r_valid1 <= '0;
                r_lru    <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tag_ctrl_2way.sv
`default_nettype none
// ============================================================================
// tb_tag_ctrl_2way : directed bench with a set/way scoreboard and tag SRAM model
// Revision 1.0     : initial release
// ============================================================================
`timescale 1ns/1ps
module tb_tag_ctrl_2way;

    localparam int IDX_W = 5;
    localparam int TAG_W = 23;
    localparam int SETS  = 32;

    logic             CK = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic             req_op;
    logic [31:0]      req_addr;
    logic             req_way;
    logic             flush_req;
    logic             resp_valid;
    logic             resp_hit;
    logic             resp_way;
    logic             resp_victim;
    logic             busy;
    logic             ta_cs;
    logic             ta_oe;
    logic [1:0]       ta_web;
    logic [IDX_W-1:0] ta_a;
    logic [TAG_W-1:0] ta_di;
    logic [TAG_W-1:0] ta_do0;
    logic [TAG_W-1:0] ta_do1;

    int total = 0;
    int bad   = 0;

    always #5 CK = ~CK;

    tag_ctrl_2way dut (
        .CK          (CK),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_addr    (req_addr),
        .req_way     (req_way),
        .flush_req   (flush_req),
        .resp_valid  (resp_valid),
        .resp_hit    (resp_hit),
        .resp_way    (resp_way),
        .resp_victim (resp_victim),
        .busy        (busy),
        .ta_cs       (ta_cs),
        .ta_oe       (ta_oe),
        .ta_web      (ta_web),
        .ta_a        (ta_a),
        .ta_di       (ta_di),
        .ta_do0      (ta_do0),
        .ta_do1      (ta_do1)
    );

    // Tag SRAM: synchronous write, registered read data.
    logic [TAG_W-1:0] mem0 [SETS];
    logic [TAG_W-1:0] mem1 [SETS];
    always @(posedge CK) begin
        if (ta_cs) begin
            if (!ta_web[0]) mem0[ta_a] <= ta_di;
            if (!ta_web[1]) mem1[ta_a] <= ta_di;
            if (ta_oe) begin
                ta_do0 <= mem0[ta_a];
                ta_do1 <= mem1[ta_a];
            end
        end
    end

    // Reference: per-set valid/tag/LRU tables and pending-lookup bookkeeping.
    bit               mv   [SETS][2];
    logic [TAG_W-1:0] mtag [SETS][2];
    bit               mlru [SETS];
    int               sweep_left = SETS;
    bit               cmp_pend   = 1'b0;
    int               c_idx;
    logic [TAG_W-1:0] c_tag;
    bit               e_rv, e_hit, e_way, e_vic;
    bit               chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < SETS; s++) begin
            mv[s][0] = 1'b0;
            mv[s][1] = 1'b0;
            mlru[s]  = 1'b0;
        end
    endtask

    always @(posedge CK) begin
        bit h0, h1;
        int idx;
        e_rv = 1'b0;
        if (rst) begin
            model_clear();
            sweep_left = SETS;
            cmp_pend   = 1'b0;
            e_hit = 1'b0; e_way = 1'b0; e_vic = 1'b0;
            chk_en = 1'b1;
        end else if (sweep_left > 0) begin
            sweep_left--;
        end else if (cmp_pend) begin
            h0 = mv[c_idx][0] && (mtag[c_idx][0] == c_tag);
            h1 = mv[c_idx][1] && (mtag[c_idx][1] == c_tag);
            e_rv  = 1'b1;
            e_hit = h0 || h1;
            e_way = h1 && !h0;
            e_vic = !mv[c_idx][0] ? 1'b0 : !mv[c_idx][1] ? 1'b1 : mlru[c_idx];
            if (e_hit) mlru[c_idx] = !e_way;
            cmp_pend = 1'b0;
            if (flush_req) begin
                model_clear();
                sweep_left = SETS;
            end
        end else if (flush_req) begin
            model_clear();
            sweep_left = SETS;
        end else if (req_valid) begin
            idx = int'(req_addr[8:4]);
            if (!req_op) begin
                cmp_pend = 1'b1;
                c_idx    = idx;
                c_tag    = req_addr[31:9];
            end else begin
                mv[idx][req_way]   = 1'b1;
                mtag[idx][req_way] = req_addr[31:9];
                mlru[idx]          = !req_way;
                e_rv  = 1'b1;
                e_hit = 1'b0;
                e_way = req_way;
                e_vic = !mv[idx][0] ? 1'b0 : !mv[idx][1] ? 1'b1 : mlru[idx];
            end
        end
    end

    // Every-cycle comparison against the reference.
    always @(negedge CK) begin
        bit               x_rdy, x_cs, x_oe;
        logic [1:0]       x_web;
        logic [IDX_W-1:0] x_a;
        logic [TAG_W-1:0] x_di;
        if (chk_en) begin
            x_rdy = (sweep_left == 0) && !cmp_pend && !flush_req;
            chk("busy",        busy,        sweep_left > 0);
            chk("req_ready",   req_ready,   x_rdy);
            chk("resp_valid",  resp_valid,  e_rv);
            chk("resp_hit",    resp_hit,    e_hit);
            chk("resp_way",    resp_way,    e_way);
            chk("resp_victim", resp_victim, e_vic);
            x_cs = 1'b0; x_oe = 1'b0; x_web = 2'b11; x_a = '0; x_di = '0;
            if (sweep_left > 0) begin
                x_cs = 1'b1; x_web = 2'b00; x_a = IDX_W'(SETS - sweep_left);
            end else if (x_rdy && req_valid) begin
                x_cs = 1'b1;
                x_a  = req_addr[8:4];
                if (!req_op) x_oe = 1'b1;
                else begin
                    x_web = req_way ? 2'b01 : 2'b10;
                    x_di  = req_addr[31:9];
                end
            end
            chk("ta_cs",  ta_cs,  x_cs);
            chk("ta_oe",  ta_oe,  x_oe);
            chk("ta_web", ta_web, x_web);
            if (x_cs) chk("ta_a", ta_a, x_a);
            if (x_web != 2'b11) chk("ta_di", ta_di, x_di);
        end
    end

    // Single-cycle request issued from posedge+1; returns at posedge+1.
    task automatic do_req(input bit op, input logic [31:0] addr, input bit way);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_way = way;
        @(posedge CK); #1;
        req_valid = 1'b0;
    endtask

    task automatic expect_resp(input int lat, input bit hit, input bit way,
                               input bit vic, input string nm);
        repeat (lat) @(negedge CK);
        chk({nm, ".valid"},  resp_valid,  1'b1);
        chk({nm, ".hit"},    resp_hit,    hit);
        chk({nm, ".way"},    resp_way,    way);
        chk({nm, ".victim"}, resp_victim, vic);
        @(posedge CK); #1;
    endtask

    task automatic wait_sweep(input int exp_cycles, input string nm);
        int n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CK);
            if (busy) n++;
            else break;
        end
        chk({nm, ".busy_cycles"}, n, exp_cycles);
        chk({nm, ".ready"}, req_ready, 1'b1);
        @(posedge CK); #1;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_addr = '0;
        req_way = 1'b0; flush_req = 1'b0;
        repeat (2) @(posedge CK);
        #1 rst = 1'b0;
        wait_sweep(32, "init");

        do_req(1'b0, 32'h0000_0120, 1'b0); expect_resp(2, 0, 0, 0, "lk_cold");
        do_req(1'b1, 32'h0000_0120, 1'b0); expect_resp(1, 0, 0, 1, "fill_s12_w0");
        do_req(1'b0, 32'h0000_0120, 1'b0); expect_resp(2, 1, 0, 1, "lk_hit_w0");
        do_req(1'b0, 32'h0000_0320, 1'b0); expect_resp(2, 0, 0, 1, "lk_miss_half");
        do_req(1'b1, 32'h0000_0320, 1'b1); expect_resp(1, 0, 1, 0, "fill_s12_w1");
        do_req(1'b0, 32'h0000_0120, 1'b0); expect_resp(2, 1, 0, 0, "lk_hit_w0_b");
        do_req(1'b0, 32'h0000_0520, 1'b0); expect_resp(2, 0, 0, 1, "lk_miss_vic1");
        do_req(1'b0, 32'h0000_0320, 1'b0); expect_resp(2, 1, 1, 1, "lk_hit_w1");
        do_req(1'b0, 32'h0000_0520, 1'b0); expect_resp(2, 0, 0, 0, "lk_miss_vic0");

        // Boundary sets and all-ones tag; way 1 of set 0 holds a scrubbed zero tag.
        do_req(1'b1, 32'hFFFF_FFF0, 1'b1); expect_resp(1, 0, 1, 0, "fill_s31");
        do_req(1'b0, 32'hFFFF_FFFF, 1'b0); expect_resp(2, 1, 1, 0, "lk_s31");
        do_req(1'b1, 32'h0000_0200, 1'b0); expect_resp(1, 0, 0, 1, "fill_s0");
        do_req(1'b0, 32'h0000_0000, 1'b0); expect_resp(2, 0, 0, 1, "lk_s0_zero_tag");

        // Fill immediately followed by a lookup of the same line.
        req_valid = 1'b1; req_op = 1'b1; req_addr = 32'h0000_0410; req_way = 1'b0;
        @(posedge CK); #1;
        req_op = 1'b0;
        @(posedge CK); #1;
        req_valid = 1'b0;
        expect_resp(2, 1, 0, 1, "b2b_fill_lk");

        // Flush collides with a request in IDLE.
        req_valid = 1'b1; req_op = 1'b0; req_addr = 32'h0000_0120; flush_req = 1'b1;
        @(negedge CK);
        chk("flush_coll.ready", req_ready, 1'b0);
        @(posedge CK); #1;
        req_valid = 1'b0; flush_req = 1'b0;
        wait_sweep(32, "flush_idle");
        do_req(1'b0, 32'h0000_0120, 1'b0); expect_resp(2, 0, 0, 0, "post_flush_a");
        do_req(1'b0, 32'hFFFF_FFF0, 1'b0); expect_resp(2, 0, 0, 0, "post_flush_b");

        // Flush during CMP still yields the pending response.
        do_req(1'b1, 32'h0000_0120, 1'b0); expect_resp(1, 0, 0, 1, "fill_pre_fc");
        do_req(1'b0, 32'h0000_0120, 1'b0);
        flush_req = 1'b1;
        @(posedge CK); #1;
        flush_req = 1'b0;
        @(negedge CK);
        chk("flush_cmp.valid", resp_valid, 1'b1);
        chk("flush_cmp.hit",   resp_hit,   1'b1);
        chk("flush_cmp.busy",  busy,       1'b1);
        wait_sweep(31, "flush_cmp");
        do_req(1'b0, 32'h0000_0120, 1'b0); expect_resp(2, 0, 0, 0, "post_fc");

        // Reset during CMP drops the response.
        do_req(1'b1, 32'h0000_0120, 1'b1); expect_resp(1, 0, 1, 0, "fill_pre_rst");
        do_req(1'b0, 32'h0000_0120, 1'b0);
        rst = 1'b1;
        @(posedge CK); #1;
        rst = 1'b0;
        @(negedge CK);
        chk("rst_cmp.valid", resp_valid, 1'b0);
        chk("rst_cmp.busy",  busy,       1'b1);
        wait_sweep(31, "rst_cmp");
        do_req(1'b0, 32'h0000_0120, 1'b0); expect_resp(2, 0, 0, 0, "post_rst");

        repeat (2) @(posedge CK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/tag_ctrl_2way.md
Name: tag_ctrl_2way

Overview:
- Controller for the 2-way, 32-set, 23-bit tag array wrapper.
- Sequences tag lookups, compares both ways and reports hit/way and a replacement victim.
- Performs tag fills, and keeps per-set valid and LRU state in flops.
- Scrubs the tag SRAM with zeros after reset and on flush; sits between the cache FSM and the tag array.

Parameters:
- ADDR_W, 32, request address width.
- OFF_W, 4, line offset bits (address bits [3:0]).
- IDX_W, 5, set index bits (address bits [8:4]); SETS = 2**IDX_W.
- TAG_W, 23, tag bits (address bits [31:9]); TAG_W+IDX_W+OFF_W must equal ADDR_W.

Ports:
- CK  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_op  in  1  0 = LOOKUP, 1 = FILL.
- req_addr  in  ADDR_W  request address.
- req_way  in  1  target way for FILL.
- flush_req  in  1  one-cycle pulse; invalidate and scrub all sets.
- resp_valid  out  1  one-cycle response pulse.
- resp_hit  out  1  LOOKUP hit.
- resp_way  out  1  hit way (LOOKUP hit) or written way (FILL).
- resp_victim  out  1  replacement way for this set.
- busy  out  1  high in INIT/FLUSH sweep.
- ta_cs  out  1  tag array select.
- ta_oe  out  1  tag array output enable.
- ta_web  out  2  per-way write enable, active low.
- ta_a  out  IDX_W  tag array set address.
- ta_di  out  TAG_W  tag write data.
- ta_do0  in  TAG_W  way-0 read data, valid the cycle after the read address is clocked.
- ta_do1  in  TAG_W  way-1 read data, same timing.

Behaviour:
- States: SWEEP, IDLE, CMP.
- Reset:
  - state = SWEEP, sweep counter = 0.
  - valid[*][*] = 0, lru[*] = 0.
  - resp_valid = 0, resp_hit = 0, resp_way = 0, resp_victim = 0, busy = 1.
- Idle outputs: ta_web = 2'b11, ta_cs = 0, ta_oe = 0.
- SWEEP:
  - Each cycle: ta_cs = 1, ta_web = 2'b00, ta_a = counter, ta_di = 0; counter increments.
  - After set SETS-1 is written (32 cycles), go to IDLE and clear busy.
  - req_ready = 0 throughout; flush_req is ignored (the sweep is not restarted).
- req_ready:
  - Equals (state == IDLE) & !flush_req, combinationally.
  - flush_req in IDLE always wins over a concurrent request; that request is not accepted.
- flush_req in IDLE:
  - Next state SWEEP, counter = 0, all valid bits and LRU bits cleared on the same edge.
- flush_req in CMP:
  - Latched; the pending LOOKUP response is still produced.
  - The following cycle enters SWEEP.
- LOOKUP accepted in IDLE at cycle t:
  - ta_cs = 1, ta_oe = 1, ta_a = req_addr[8:4] driven combinationally in cycle t.
  - Index and tag are registered; state goes to CMP.
- CMP (cycle t+1):
  - hit0 = valid[idx][0] & (ta_do0 == tag); hit1 = valid[idx][1] & (ta_do1 == tag).
  - Both hit (illegal) → report way 0.
  - Registered outputs:
    - resp_hit = hit0 | hit1.
    - resp_way = hit1 & !hit0.
    - resp_victim = !valid[idx][0] ? 0 : !valid[idx][1] ? 1 : lru[idx].
  - On hit: lru[idx] = ~resp_way (lru points at the least-recently-used way).
  - On miss: no state change.
  - Return to IDLE; resp_valid is asserted in cycle t+2 for exactly one cycle.
  - Throughput: one lookup per 2 cycles.
- FILL accepted in IDLE at cycle t:
  - ta_cs = 1, ta_web[req_way] = 0 (other bit 1), ta_a = index, ta_di = req_addr[31:9], all in cycle t.
  - On the edge: valid[idx][req_way] = 1, lru[idx] = ~req_way.
  - Cycle t+1: resp_valid = 1, resp_hit = 0, resp_way = req_way.
  - resp_victim = the recomputed victim for the set after the update.
  - State stays IDLE, so a new request may be accepted in t+1.
- Response hold:
  - All resp_* outputs hold their values when resp_valid = 0.
  - resp_valid has no backpressure; the consumer must take it.
- Reset mid-operation:
  - Any state → SWEEP with counter = 0.
  - Any pending CMP response is dropped; no resp_valid follows.

Test Plan:
- Reset → busy = 1 for exactly 32 cycles, ta_web = 2'b00 with ta_a counting 0..31 and ta_di = 0; then busy = 0 and req_ready = 1.
- LOOKUP 0x0000_0120 after init → resp_valid 2 cycles after accept, resp_hit = 0, resp_victim = 0.
- FILL 0x0000_0120 way 0, then LOOKUP 0x0000_0120 → resp_hit = 1, resp_way = 0; the next LOOKUP miss to tag 0x1 in set 0x12 gives resp_victim = 1.
- FILL way 1 with address 0x0000_0320 (set 0x12, tag 0x1), then LOOKUP 0x0000_0120 (hit way 0) → a miss lookup to that set gives resp_victim = 1; after LOOKUP 0x0000_0320 hits way 1, the same miss gives resp_victim = 0.
- flush_req pulsed in the same cycle as req_valid in IDLE → req_ready = 0 that cycle, a 32-cycle sweep follows, and a later LOOKUP of any previously filled address misses.
- rst asserted in CMP → no resp_valid is produced, a full 32-cycle sweep follows, and all lookups afterwards miss.
